// File: rtl/seq_multiplier_4x4.sv
// seq_multiplier_4x4 -- 4x4 unsigned shift-and-add multiplier with
// valid/ready handshakes on both sides.
//
// Ports:
//   clk        in   1  clock, all state updates on the rising edge
//   reset      in   1  synchronous, active-high
//   in_valid   in   1  operand pair on a/b is valid
//   in_ready   out  1  block can accept an operand pair (IDLE only)
//   a          in   4  unsigned multiplicand
//   b          in   4  unsigned multiplier
//   out_valid  out  1  product is valid (DONE only)
//   out_ready  in   1  downstream accepts the product
//   product    out  8  unsigned a*b, held until the output handshake
//   busy       out  1  high whenever the FSM is not IDLE
//
// Also contains ripple_carry_adder_4_bit, the shared 4-bit adder used for
// every partial-product addition.

// ripple_carry_adder_4_bit -- plain 4-bit ripple-carry adder.
// Ports: a, b (4-bit addends), carry_in, out (4-bit sum), carry_out.
module ripple_carry_adder_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  output logic [3:0] out,
  output logic       carry_out
);

  logic [4:0] carry;

  always_comb begin
    carry    = '0;
    out      = '0;
    carry[0] = carry_in;
    for (int unsigned i = 0; i < 4; i++) begin
      out[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    carry_out = carry[4];
  end

endmodule

module seq_multiplier_4x4 (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] product,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     next_state;

  logic [3:0] mcand;
  logic [3:0] acc;
  logic [3:0] mplier;
  logic [1:0] cnt;
  logic [7:0] product_q;

  logic [3:0] add_out;
  logic       add_carry;
  logic [4:0] sum;
  logic [7:0] shifted;

  ripple_carry_adder_4_bit u_adder (
    .a         (acc),
    .b         (mcand),
    .carry_in  (1'b0),
    .out       (add_out),
    .carry_out (add_carry)
  );

  // Partial-product step: add the multiplicand only when the current
  // multiplier LSB is set, then shift {sum, mplier} right by one.
  always_comb begin
    sum     = mplier[0] ? {add_carry, add_out} : {1'b0, acc};
    shifted = {sum, mplier[3:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (cnt == 2'd3) begin
          next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand     <= '0;
      acc       <= '0;
      mplier    <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc    <= shifted[7:4];
          mplier <= shifted[3:0];
          cnt    <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            product_q <= shifted;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier_4x4.sv
// Self-checking bench for seq_multiplier_4x4: directed vectors with
// hand-computed products plus a full 256-pair sweep with random stalls.
module tb_seq_multiplier_4x4;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] product;
  logic       busy;

  int errors;
  int checks;

  seq_multiplier_4x4 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one pair and lets the accept edge happen.
  task automatic accept(input logic [3:0] x, input logic [3:0] y);
    a        = x;
    b        = y;
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready a=%0d b=%0d: in_ready=%b expected 1", x, y, in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (product !== 8'h00) begin
      errors++;
      $display("FAIL reset_product: got %h expected 00", product);
    end
  endtask

  // 3*5: out_valid exactly 4 edges after accept, then back to IDLE.
  task automatic test_basic();
    out_ready = 1'b1;
    accept(4'd3, 4'd5);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_run_flags: busy=%b in_ready=%b expected 1/0", busy, in_ready);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_early_valid edge %0d: out_valid=%b expected 0", i, out_valid);
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || product !== 8'h0F) begin
      errors++;
      $display("FAIL basic_result: out_valid=%b product=%h expected 1/0f", out_valid, product);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_return_idle: out_valid=%b in_ready=%b busy=%b expected 0/1/0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_corners();
    logic [3:0] va [3];
    logic [3:0] vb [3];
    logic [7:0] vp [3];
    va[0] = 4'd15; vb[0] = 4'd15; vp[0] = 8'hE1;
    va[1] = 4'd0;  vb[1] = 4'd9;  vp[1] = 8'h00;
    va[2] = 4'd9;  vb[2] = 4'd0;  vp[2] = 8'h00;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      accept(va[k], vb[k]);
      repeat (4) tick();
      checks++;
      if (out_valid !== 1'b1 || product !== vp[k]) begin
        errors++;
        $display("FAIL corner %0d*%0d: out_valid=%b product=%h expected 1/%h",
                 va[k], vb[k], out_valid, product, vp[k]);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL corner_drop %0d*%0d: out_valid=%b expected 0", va[k], vb[k], out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    accept(4'd7, 4'd6);
    repeat (4) tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || product !== 8'h2A || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall cycle %0d: out_valid=%b product=%h in_ready=%b expected 1/2a/0",
                 i, out_valid, product, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_single_transfer: out_valid=%b expected 0", out_valid);
    end
  endtask

  // Operands changing with in_valid held high during RUN must not leak in.
  task automatic test_back_to_back();
    out_ready = 1'b1;
    accept(4'd2, 4'd3);
    a        = 4'd15;
    b        = 4'd15;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_ready_run %0d: in_ready=%b expected 0", i, in_ready);
      end
      tick();
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || product !== 8'h06) begin
      errors++;
      $display("FAIL b2b_first: out_valid=%b product=%h expected 1/06", out_valid, product);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: in_ready=%b busy=%b expected 1/0", in_ready, busy);
    end
    accept(4'd15, 4'd15);
    repeat (4) tick();
    checks++;
    if (out_valid !== 1'b1 || product !== 8'hE1) begin
      errors++;
      $display("FAIL b2b_second: out_valid=%b product=%h expected 1/e1", out_valid, product);
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    out_ready = 1'b1;
    accept(4'd3, 4'd5);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || product !== 8'h00 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b in_ready=%b product=%h out_valid=%b expected 0/1/00/0",
               busy, in_ready, product, out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrun_no_valid cycle %0d: out_valid=%b expected 0", i, out_valid);
      end
    end
  endtask

  task automatic test_sweep();
    int  accepts;
    int  transfers;
    int  budget;
    bit  done;
    accepts   = 0;
    transfers = 0;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        a        = 4'(x);
        b        = 4'(y);
        in_valid = 1'b1;
        budget   = 0;
        while (in_ready !== 1'b1 && budget < 20) begin
          tick();
          budget++;
        end
        tick();
        accepts++;
        in_valid = 1'b0;
        done     = 1'b0;
        budget   = 0;
        while (!done && budget < 40) begin
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid === 1'b1 && out_ready === 1'b1) begin
            transfers++;
            done = 1'b1;
            checks++;
            if (product !== 8'(x * y)) begin
              errors++;
              $display("FAIL sweep %0d*%0d: product=%h expected %h", x, y, product, 8'(x * y));
            end
          end
          tick();
          budget++;
        end
        if (!done) begin
          checks++;
          errors++;
          $display("FAIL sweep_timeout %0d*%0d: out_valid=%b expected handshake", x, y, out_valid);
        end
      end
    end
    out_ready = 1'b0;
    checks++;
    if (transfers !== accepts) begin
      errors++;
      $display("FAIL sweep_count: transfers=%0d expected %0d", transfers, accepts);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_back_to_back();
    test_reset_midrun();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
